// File: rtl/sp_pkg.sv
// Shared constants for the serial-to-parallel link: comma byte,
// receiver state encoding and counter widths.
package sp_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_W  = 3;
  localparam int COM_W  = 4;
  localparam int MIS_W  = 2;

  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

endpackage

// File: rtl/sp_shift_detect.sv
// Serial shift register (MSB first) with a comma comparator on the
// value that will be loaded at this edge.
module sp_shift_detect
  import sp_pkg::*;
(
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] sr_next,
  output logic              is_comma
);

  logic [BYTE_W-1:0] sr_q;

  assign sr_next  = {sr_q[BYTE_W-2:0], data_in};
  assign is_comma = (sr_next == COMMA);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_next;
    end
  end

endmodule

// File: rtl/serie_paralelo_rx.sv
// Comma-locked serial-to-parallel receiver.
// Optional SP_RELOCK_EN: drop lock after two off-phase commas.
module serie_paralelo_rx
  import sp_pkg::*;
#(
  parameter int BC_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  logic [BYTE_W-1:0] sr_next;
  logic              is_comma;

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [COM_W-1:0]  comcnt_q, comcnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;
  logic              boundary;

`ifdef SP_RELOCK_EN
  logic [MIS_W-1:0]  mis_q, mis_d;
`endif

  sp_shift_detect u_sd (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .sr_next  (sr_next),
    .is_comma (is_comma)
  );

  assign boundary = (bitcnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    comcnt_d = comcnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = active_q;
`ifdef SP_RELOCK_EN
    mis_d    = mis_q;
`endif
    unique case (state_q)
      SEARCH: begin
        bitcnt_d = '0;
        if (is_comma) begin
          comcnt_d = 4'd1;
          if (BC_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comcnt_d = comcnt_q + 4'd1;
            if (comcnt_q + 4'd1 == COM_W'(BC_COUNT)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            comcnt_d = '0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end
        end
`ifdef SP_RELOCK_EN
        // A comma seen off the byte grid means the grid has slipped
        if (is_comma) begin
          if (boundary) begin
            mis_d = '0;
          end else if (mis_q == 2'd1) begin
            mis_d    = '0;
            state_d  = SEARCH;
            bitcnt_d = '0;
            comcnt_d = '0;
            active_d = 1'b0;
            valid_d  = 1'b0;
          end else begin
            mis_d = mis_q + 2'd1;
          end
        end
`endif
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      bitcnt_q <= '0;
      comcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef SP_RELOCK_EN
      mis_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      comcnt_q <= comcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
`ifdef SP_RELOCK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx: byte vector table with a data scoreboard
// plus hand sequences for reset, bit offset and phase slip.
module tb_serie_paralelo_rx;

  typedef struct packed {
    logic [7:0] b;
    logic       act;
    logic       val;
    logic [7:0] dat;
  } vec_t;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int errors = 0;
  int checks = 0;

  vec_t       tab[$];
  logic [7:0] sb_q[$];
  int         s0, s1, s2, s3, s4, s5;

  logic       p_act;
  logic       p_val;
  logic [7:0] p_dat;

  serie_paralelo_rx #(.BC_COUNT(4)) dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk_8f = ~clk_8f;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [7:0] b, logic a, logic v, logic [7:0] d);
    vec_t r;
    r.b = b; r.act = a; r.val = v; r.dat = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h required %02h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_prev(input logic a, input logic v, input logic [7:0] d);
    p_act = a; p_val = v; p_dat = d;
  endtask

  task automatic chk_prev(input string nm);
    chk({nm, "_act"}, {7'd0, active}, {7'd0, p_act});
    chk({nm, "_val"}, {7'd0, valid_out}, {7'd0, p_val});
    chk({nm, "_dat"}, data_out, p_dat);
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (hold && i != 0) chk_prev("hold");
    end
  endtask

  task automatic run_rec(input vec_t r);
    logic [7:0] e;
    if (r.val) sb_q.push_back(r.dat);
    send_byte(r.b, 1'b1);
    chk("byte_act", {7'd0, active}, {7'd0, r.act});
    chk("byte_val", {7'd0, valid_out}, {7'd0, r.val});
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexp: got %02h required no output", data_out);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", data_out, e);
      end
    end else begin
      if (r.val && sb_q.size() != 0) void'(sb_q.pop_front());
      chk("held_dat", data_out, r.dat);
    end
    set_prev(r.act, r.val, r.dat);
  endtask

  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i < hi; i++) run_rec(tab[i]);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 chk_prev("pre_rst_dummy_skip") ;
  endtask

  task automatic pulse_reset(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_act"}, {7'd0, active}, 8'd0);
    chk({nm, "_val"}, {7'd0, valid_out}, 8'd0);
    chk({nm, "_dat"}, data_out, 8'h00);
    #2 reset = 1'b0;
    sb_q.delete();
    set_prev(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    set_prev(1'b0, 1'b0, 8'h00);

    s0 = tab.size();
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h00));
    tab.push_back(mk(8'hA5, 1'b1, 1'b1, 8'hA5));
    tab.push_back(mk(8'h3C, 1'b1, 1'b1, 8'h3C));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h3C));
    tab.push_back(mk(8'h12, 1'b1, 1'b1, 8'h12));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h12));
    tab.push_back(mk(8'h34, 1'b1, 1'b1, 8'h34));
    tab.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00));
    tab.push_back(mk(8'hFF, 1'b1, 1'b1, 8'hFF));
    tab.push_back(mk(8'h12, 1'b1, 1'b1, 8'h12));
    s1 = tab.size();
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h00));
    tab.push_back(mk(8'h12, 1'b1, 1'b1, 8'h12));
    s2 = tab.size();
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h00));
    tab.push_back(mk(8'h5A, 1'b1, 1'b1, 8'h5A));
    s3 = tab.size();
    tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'h11, 1'b0, 1'b0, 8'h00));
    for (int i = 0; i < 3; i++) tab.push_back(mk(8'hBC, 1'b0, 1'b0, 8'h00));
    tab.push_back(mk(8'hBC, 1'b1, 1'b0, 8'h00));
    tab.push_back(mk(8'h77, 1'b1, 1'b1, 8'h77));
    s4 = tab.size();
    s5 = s4;

    repeat (2) @(posedge clk_8f);
    #1;
    chk("rst_act", {7'd0, active}, 8'd0);
    chk("rst_val", {7'd0, valid_out}, 8'd0);
    chk("rst_dat", data_out, 8'h00);
    reset = 1'b0;

    // Lock, data, comma between data, persistence
    run_seg(s0, s1);

    // Async reset mid-byte while locked
    send_bit(1'b1); chk_prev("mid");
    send_bit(1'b0); chk_prev("mid");
    send_bit(1'b1); chk_prev("mid");
    pulse_reset("async_rst");
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] t;
      t = 8'h3C;
      send_bit(t[i]);
      chk_prev("post_rst");
    end
    run_seg(s1, s2);

    // One-bit phase slip followed by a comma stream
    send_bit(1'b0);
    chk_prev("slip_bit");
    for (int k = 1; k <= 6; k++) begin
      send_byte(8'hBC, 1'b0);
`ifdef SP_RELOCK_EN
      chk("slip_act", {7'd0, active},
          (k == 1 || k == 6) ? 8'd1 : 8'd0);
      chk("slip_val", {7'd0, valid_out}, (k == 1) ? 8'd1 : 8'd0);
`else
      chk("slip_act", {7'd0, active}, 8'd1);
      chk("slip_val", {7'd0, valid_out}, 8'd1);
`endif
      chk("slip_dat", data_out, 8'h5E);
    end
`ifdef SP_RELOCK_EN
    set_prev(1'b1, 1'b0, 8'h5E);
    run_rec(mk(8'h33, 1'b1, 1'b1, 8'h33));
`endif

    // Random bit offset before the comma run
    pulse_reset("rst2");
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_prev("offs");
    end
    run_seg(s2, s3);

    // Broken comma run returns to search
    pulse_reset("rst3");
    run_seg(s3, s5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
